auc_alu_arb: RTL and testbench

//  Shares the single field-arithmetic ALU and its scratch-RAM port among NREQ

---
 rtl/auc_arb_pkg.sv | 25 ++
 rtl/auc_arb_pick.sv | 46 ++++
 rtl/auc_alu_arb.sv | 157 +++++++++++++++
 tb/tb_auc_alu_arb.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/auc_arb_pkg.sv
// Shared types and constants for the ALU/RAM arbiter.
package auc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [3:0] OP_FA  = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_INV = 4'd2;

  // One-hot (up to 8 requesters) to binary index; returns 0 for an all-zero vector.
  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/auc_arb_pick.sv
// One-hot requester picker. AUC_ARB_RR_EN selects round-robin from ptr,
// otherwise fixed priority with the lowest index winning.
module auc_arb_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
`ifdef AUC_ARB_RR_EN
  input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr,
`endif
  output logic [NREQ-1:0] pick
);

`ifdef AUC_ARB_RR_EN
  int unsigned idx;
  logic        found;

  // Scan from the pointer upward, wrapping, and take the first active request.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  logic found;

  // Lowest active index wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && req[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/auc_alu_arb.sv
// Arbiter sharing one field ALU and its scratch-RAM port among NREQ point engines.
// Optional macro AUC_ARB_RR_EN: round-robin arbitration (default: fixed priority).
module auc_alu_arb
  import auc_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned ADDR  = 5,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned OPW   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*OPW-1:0]   req_opcode,
  input  logic [NREQ*WIDTH-1:0] req_const,
  input  logic [NREQ-1:0]       req_carry,
  input  logic [NREQ*ADDR-1:0]  req_radd,
  input  logic [NREQ-1:0]       req_wen,
  input  logic [NREQ*ADDR-1:0]  req_wadd,
  input  logic [NREQ*WIDTH-1:0] req_wdat,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      res_dat,
  output logic                  alu_start,
  output logic [OPW-1:0]        alu_opcode,
  output logic [WIDTH-1:0]      alu_const,
  output logic                  alu_carry,
  input  logic                  alu_vld,
  input  logic [WIDTH-1:0]      alu_dat,
  output logic [ADDR-1:0]       ram_radd,
  output logic                  ram_wen,
  output logic [ADDR-1:0]       ram_wadd,
  output logic [WIDTH-1:0]      ram_wdat,
  output logic                  busy,
  output logic                  arb_err
);

  state_t            state;
  state_t            state_nx;
  logic              take_c;
  logic [NREQ-1:0]   pick;
  logic [OPW-1:0]    sel_op;
  logic [WIDTH-1:0]  sel_const;
  logic              sel_carry;

`ifdef AUC_ARB_RR_EN
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr;

  // Next search starts one past the requester just granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take_c) begin
      ptr <= PW'((32'(oh_to_idx(8'(pick))) + 32'd1) % NREQ);
    end
  end
`endif

  auc_arb_pick #(.NREQ(NREQ)) u_pick (
    .req  (req),
`ifdef AUC_ARB_RR_EN
    .ptr  (ptr),
`endif
    .pick (pick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; take_c marks the IDLE->ISSUE grant.
  always_comb begin
    state_nx = state;
    take_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nx = ISSUE;
          take_c   = 1'b1;
        end
      end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (alu_vld) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand fields of the winner, AND-OR muxed from the one-hot pick.
  always_comb begin
    sel_op    = '0;
    sel_const = '0;
    sel_carry = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick[i]) begin
        sel_op    = sel_op    | req_opcode[i*OPW +: OPW];
        sel_const = sel_const | req_const[i*WIDTH +: WIDTH];
        sel_carry = sel_carry | req_carry[i];
      end
    end
  end

  // Grant, ALU command, result latch and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt        <= '0;
      done       <= '0;
      res_dat    <= '0;
      alu_start  <= 1'b0;
      alu_opcode <= '0;
      alu_const  <= '0;
      alu_carry  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      alu_start <= take_c;
      busy      <= (state_nx != IDLE);
      done      <= '0;
      if (take_c) begin
        gnt        <= pick;
        alu_opcode <= sel_op;
        alu_const  <= sel_const;
        alu_carry  <= sel_carry;
      end
      if (state == WAIT && alu_vld) begin
        res_dat <= alu_dat;
        done    <= gnt;
      end
      if (state == DONE) gnt <= '0;
    end
  end

  // Sticky error: a result arriving when none is outstanding.
  always_ff @(posedge clk) begin
    if (rst)                            arb_err <= 1'b0;
    else if (alu_vld && state != WAIT)  arb_err <= 1'b1;
  end

  // RAM port follows the registered owner; zero when nobody owns it.
  always_comb begin
    ram_radd = '0;
    ram_wen  = 1'b0;
    ram_wadd = '0;
    ram_wdat = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        ram_radd = ram_radd | req_radd[i*ADDR +: ADDR];
        ram_wen  = ram_wen  | req_wen[i];
        ram_wadd = ram_wadd | req_wadd[i*ADDR +: ADDR];
        ram_wdat = ram_wdat | req_wdat[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_auc_alu_arb.sv
// Directed bench for auc_alu_arb with a result scoreboard.
module tb_auc_alu_arb;
  import auc_arb_pkg::*;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned ADDR  = 5;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned OPW   = 4;

  typedef struct {
    logic [NREQ-1:0]  mask;
    logic [WIDTH-1:0] dat;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*OPW-1:0]   req_opcode;
  logic [NREQ*WIDTH-1:0] req_const;
  logic [NREQ-1:0]       req_carry;
  logic [NREQ*ADDR-1:0]  req_radd;
  logic [NREQ-1:0]       req_wen;
  logic [NREQ*ADDR-1:0]  req_wadd;
  logic [NREQ*WIDTH-1:0] req_wdat;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic [WIDTH-1:0]      res_dat;
  logic                  alu_start;
  logic [OPW-1:0]        alu_opcode;
  logic [WIDTH-1:0]      alu_const;
  logic                  alu_carry;
  logic                  alu_vld;
  logic [WIDTH-1:0]      alu_dat;
  logic [ADDR-1:0]       ram_radd;
  logic                  ram_wen;
  logic [ADDR-1:0]       ram_wadd;
  logic [WIDTH-1:0]      ram_wdat;
  logic                  busy;
  logic                  arb_err;

  int   checks;
  int   errors;
  exp_t sb[$];

  auc_alu_arb #(.WIDTH(WIDTH), .ADDR(ADDR), .NREQ(NREQ), .OPW(OPW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_const(req_const),
    .req_carry(req_carry), .req_radd(req_radd), .req_wen(req_wen), .req_wadd(req_wadd),
    .req_wdat(req_wdat), .gnt(gnt), .done(done), .res_dat(res_dat), .alu_start(alu_start),
    .alu_opcode(alu_opcode), .alu_const(alu_const), .alu_carry(alu_carry),
    .alu_vld(alu_vld), .alu_dat(alu_dat), .ram_radd(ram_radd), .ram_wen(ram_wen),
    .ram_wadd(ram_wadd), .ram_wdat(ram_wdat), .busy(busy), .arb_err(arb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // From the cycle the owner is known, wait lat cycles, return a result, check the done pulse.
  task automatic finish_op(input int lat, input logic [NREQ-1:0] owner, input logic [WIDTH-1:0] d);
    exp_t e;
    repeat (lat) tick();
    chk("done_early", WIDTH'(done), '0);
    alu_vld = 1'b1;
    alu_dat = d;
    sb.push_back('{mask: owner, dat: d});
    tick();
    alu_vld = 1'b0;
    alu_dat = '0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk("done_pulse", WIDTH'(done), WIDTH'(e.mask));
      chk("res_dat", res_dat, e.dat);
    end
    req = req & ~owner;
  endtask

  initial begin
    logic [NREQ-1:0] first_g;
    logic [NREQ-1:0] second_g;
    clk = 1'b0; rst = 1'b1; checks = 0; errors = 0;
    req = '0; req_opcode = '0; req_const = '0; req_carry = '0;
    req_radd = '0; req_wen = '0; req_wadd = '0; req_wdat = '0;
    alu_vld = 1'b0; alu_dat = '0;
    tick(); tick();
    chk("rst_gnt", WIDTH'(gnt), '0);
    chk("rst_busy", WIDTH'(busy), '0);
    chk("rst_start", WIDTH'(alu_start), '0);
    chk("rst_err", WIDTH'(arb_err), '0);
    rst = 1'b0;
    tick();

    // 1: two requesters, fixed start pointer 0 -> requester 1 first
    req_opcode[1*OPW +: OPW] = OP_MUL;
    req_opcode[2*OPW +: OPW] = OP_INV;
    req_const[1*WIDTH +: WIDTH] = WIDTH'(256'h1234_5678);
    req_carry = 4'b0010;
    req = 4'b0110;
    tick();
    chk("t1_gnt", WIDTH'(gnt), WIDTH'(4'b0010));
    chk("t1_start", WIDTH'(alu_start), WIDTH'(1'b1));
    chk("t1_opcode", WIDTH'(alu_opcode), WIDTH'(OP_MUL));
    chk("t1_const", alu_const, WIDTH'(256'h1234_5678));
    chk("t1_carry", WIDTH'(alu_carry), WIDTH'(1'b1));
    chk("t1_busy", WIDTH'(busy), WIDTH'(1'b1));
    finish_op(10, 4'b0010, {64'hdead_beef_0000_0001, 192'h5});
    tick();
    chk("t1_idle_gnt", WIDTH'(gnt), '0);
    chk("t1_idle_busy", WIDTH'(busy), '0);
    tick();
    chk("t1_gnt2", WIDTH'(gnt), WIDTH'(4'b0100));
    chk("t1_opcode2", WIDTH'(alu_opcode), WIDTH'(OP_INV));
    tick();
    chk("t1_start_once", WIDTH'(alu_start), '0);
    finish_op(3, 4'b0100, WIDTH'(256'h77));

    // 2: owner 0 served, then requesters 0 and 1 together
    req = 4'b0001;
    tick(); tick();
    chk("t2_gnt0", WIDTH'(gnt), WIDTH'(4'b0001));
    finish_op(2, 4'b0001, WIDTH'(256'h100));
    req = 4'b0011;
`ifdef AUC_ARB_RR_EN
    first_g = 4'b0010; second_g = 4'b0001;
`else
    first_g = 4'b0001; second_g = 4'b0010;
`endif
    tick(); tick();
    chk("t2_first", WIDTH'(gnt), WIDTH'(first_g));
    finish_op(2, first_g, WIDTH'(256'h200));
    tick(); tick();
    chk("t2_second", WIDTH'(gnt), WIDTH'(second_g));
    finish_op(2, second_g, WIDTH'(256'h300));

    // 3: owner 2 drives the RAM; requester 0 signals must not leak
    req_wen = 4'b0101;
    req_wadd[0 +: ADDR] = 5'd9;
    req_wadd[2*ADDR +: ADDR] = 5'd21;
    req_radd[0 +: ADDR] = 5'd7;
    req_radd[2*ADDR +: ADDR] = 5'd3;
    req_wdat[0 +: WIDTH] = WIDTH'(256'haaaa);
    req_wdat[2*WIDTH +: WIDTH] = WIDTH'(256'h5555);
    tick();
    chk("t3_idle_wen", WIDTH'(ram_wen), '0);
    chk("t3_idle_wadd", WIDTH'(ram_wadd), '0);
    req = 4'b0100;
    tick(); tick();
    chk("t3_wen", WIDTH'(ram_wen), WIDTH'(1'b1));
    chk("t3_wadd", WIDTH'(ram_wadd), WIDTH'(5'd21));
    chk("t3_radd", WIDTH'(ram_radd), WIDTH'(5'd3));
    chk("t3_wdat", ram_wdat, WIDTH'(256'h5555));
    finish_op(2, 4'b0100, WIDTH'(256'h400));
    req_wen = '0;
    tick();

    // 4: stray alu_vld in IDLE
    alu_vld = 1'b1; alu_dat = WIDTH'(256'hbad);
    tick();
    alu_vld = 1'b0; alu_dat = '0;
    chk("t4_err", WIDTH'(arb_err), WIDTH'(1'b1));
    chk("t4_done", WIDTH'(done), '0);
    chk("t4_busy", WIDTH'(busy), '0);
    tick();
    chk("t4_err_sticky", WIDTH'(arb_err), WIDTH'(1'b1));
    chk("t4_gnt", WIDTH'(gnt), '0);

    // 5: reset during WAIT, then a late result
    req = 4'b1000;
    tick(); tick();
    chk("t5_wait_gnt", WIDTH'(gnt), WIDTH'(4'b1000));
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    chk("t5_gnt", WIDTH'(gnt), '0);
    chk("t5_busy", WIDTH'(busy), '0);
    chk("t5_err", WIDTH'(arb_err), '0);
    chk("t5_res", res_dat, '0);
    chk("t5_opcode", WIDTH'(alu_opcode), '0);
    chk("t5_const", alu_const, '0);
    alu_vld = 1'b1; alu_dat = WIDTH'(256'h999);
    tick();
    alu_vld = 1'b0; alu_dat = '0;
    chk("t5_late_err", WIDTH'(arb_err), WIDTH'(1'b1));
    chk("t5_late_done", WIDTH'(done), '0);

    // 6: requester 0 pulses req while owner 3 waits, then withdraws
    req = 4'b1000;
    tick();
    chk("t6_gnt3", WIDTH'(gnt), WIDTH'(4'b1000));
    tick();
    req = 4'b1001;
    tick();
    req = 4'b1000;
    finish_op(4, 4'b1000, WIDTH'(256'h600));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_no_gnt", WIDTH'(gnt), '0);
      chk("t6_no_done", WIDTH'(done), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
